// File: rtl/stream_to_mem_mux.sv
// Round-robin mux of NumPorts request streams onto one in-order memory port with
// per-port fall-through response buffers. Define STREAM_TO_MEM_MUX_ERR_EN to enable err_o.
module stream_to_mem_mux #(
    parameter type         mem_req_t      = logic,
    parameter type         mem_resp_t     = logic,
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned BufDepth       = 1,
    parameter int unsigned MaxOutstanding = NumPorts * BufDepth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  mem_req_t  [NumPorts-1:0] req_i,
    input  logic      [NumPorts-1:0] req_valid_i,
    output logic      [NumPorts-1:0] req_ready_o,
    output mem_resp_t [NumPorts-1:0] resp_o,
    output logic      [NumPorts-1:0] resp_valid_o,
    input  logic      [NumPorts-1:0] resp_ready_i,
    output mem_req_t                 mem_req_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    input  mem_resp_t                mem_resp_i,
    input  logic                     mem_resp_valid_i,
    output logic                     err_o
);
    localparam int unsigned IdW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CntW    = $clog2(BufDepth + 1);
    localparam int unsigned BufPtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned IdPtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned IdCntW  = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0]   CntMax = CntW'(BufDepth);
    localparam logic [IdCntW-1:0] IdMax  = IdCntW'(MaxOutstanding);

    typedef logic [IdW-1:0] id_t;

    function automatic logic [BufPtrW-1:0] buf_next(input logic [BufPtrW-1:0] ptr);
        return (ptr == BufPtrW'(BufDepth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    function automatic logic [IdPtrW-1:0] id_next(input logic [IdPtrW-1:0] ptr);
        return (ptr == IdPtrW'(MaxOutstanding - 1)) ? '0 : ptr + 1'b1;
    endfunction

    logic [CntW-1:0]     cnt [NumPorts];
    id_t                 rr, grant, lock_id;
    logic                locked;
    logic [NumPorts-1:0] eligible, port_hs, resp_pop, port_push, store, bpop;
    logic                mem_hs;

    id_t                 id_mem [MaxOutstanding];
    logic [IdPtrW-1:0]   id_head, id_tail;
    logic [IdCntW-1:0]   id_cnt;
    logic                id_full, id_empty, id_pop;

    mem_resp_t           rbuf_mem  [NumPorts][BufDepth];
    logic [BufPtrW-1:0]  rbuf_head [NumPorts];
    logic [BufPtrW-1:0]  rbuf_tail [NumPorts];
    logic [CntW-1:0]     rbuf_cnt  [NumPorts];

    assign id_full  = (id_cnt == IdMax);
    assign id_empty = (id_cnt == '0);
    assign id_pop   = mem_resp_valid_i && !id_empty;
    assign mem_hs   = mem_req_valid_o && mem_req_ready_i;

    // Response side: an empty buffer passes the memory response straight through.
    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            port_push[p]    = id_pop && (id_mem[id_head] == id_t'(p));
            resp_valid_o[p] = (rbuf_cnt[p] != '0) || port_push[p];
            resp_o[p]       = (rbuf_cnt[p] != '0) ? rbuf_mem[p][rbuf_head[p]] : mem_resp_i;
            resp_pop[p]     = resp_valid_o[p] && resp_ready_i[p];
            bpop[p]         = resp_pop[p] && (rbuf_cnt[p] != '0);
            store[p]        = port_push[p]
                              && !((rbuf_cnt[p] == '0) && resp_ready_i[p])
                              && !((rbuf_cnt[p] == CntMax) && !bpop[p]);
        end
    end

    always_comb begin
        logic found;
        id_t  idx;
        found = 1'b0;
        idx   = '0;
        grant = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            eligible[p] = req_valid_i[p] && ((cnt[p] < CntMax) || resp_pop[p])
                          && (!id_full || id_pop);
        end
        // A stalled request keeps its port until the memory accepts it.
        if (locked && eligible[lock_id]) begin
            grant = lock_id;
            found = 1'b1;
        end
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = id_t'((32'(rr) + i) % NumPorts);
            if (!found && eligible[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        mem_req_valid_o    = |eligible;
        mem_req_o          = req_i[grant];
        req_ready_o        = '0;
        req_ready_o[grant] = mem_req_ready_i && mem_req_valid_o;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            port_hs[p] = mem_hs && (grant == id_t'(p));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr      <= '0;
            locked  <= 1'b0;
            lock_id <= '0;
            id_head <= '0;
            id_tail <= '0;
            id_cnt  <= '0;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                cnt[p]       <= '0;
                rbuf_head[p] <= '0;
                rbuf_tail[p] <= '0;
                rbuf_cnt[p]  <= '0;
            end
        end else begin
            if (mem_hs) begin
                rr <= (grant == id_t'(NumPorts - 1)) ? '0 : grant + 1'b1;
            end
            locked  <= mem_req_valid_o && !mem_req_ready_i;
            lock_id <= grant;
            if (mem_hs) id_tail <= id_next(id_tail);
            if (id_pop) id_head <= id_next(id_head);
            if (mem_hs && !id_pop)      id_cnt <= id_cnt + 1'b1;
            else if (!mem_hs && id_pop) id_cnt <= id_cnt - 1'b1;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (port_hs[p] && !resp_pop[p])      cnt[p] <= cnt[p] + 1'b1;
                else if (!port_hs[p] && resp_pop[p]) cnt[p] <= cnt[p] - 1'b1;
                if (store[p]) rbuf_tail[p] <= buf_next(rbuf_tail[p]);
                if (bpop[p])  rbuf_head[p] <= buf_next(rbuf_head[p]);
                if (store[p] && !bpop[p])      rbuf_cnt[p] <= rbuf_cnt[p] + 1'b1;
                else if (!store[p] && bpop[p]) rbuf_cnt[p] <= rbuf_cnt[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_hs) id_mem[id_tail] <= grant;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (store[p]) rbuf_mem[p][rbuf_tail[p]] <= mem_resp_i;
        end
    end

`ifdef STREAM_TO_MEM_MUX_ERR_EN
    logic [NumPorts-1:0] overflow;
    logic                err;

    always_comb begin
        overflow = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            overflow[p] = port_push[p] && (rbuf_cnt[p] == CntMax) && !bpop[p];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err <= 1'b0;
        end else if ((mem_resp_valid_i && id_empty) || (|overflow)) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_stream_to_mem_mux.sv
// Scoreboard bench for stream_to_mem_mux: 3 ports, 1-entry buffers, 2 outstanding,
// behavioural in-order memory with adjustable latency returning request ^ 16'h5A5A.
module tb_stream_to_mem_mux;
    localparam int unsigned NP = 3;
    typedef logic [15:0] word_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    word_t [NP-1:0]  req_d;
    logic  [NP-1:0]  req_v, req_r, resp_v, resp_rdy;
    word_t [NP-1:0]  resp_d;
    word_t           mem_req, mem_resp;
    logic            mem_req_v, mem_rdy, mem_resp_v, err;

    logic            inj = 1'b0;
    word_t           inj_d = '0;
    logic            mdl_v = 1'b0;
    word_t           mdl_d = '0;
    assign mem_resp_v = mdl_v | inj;
    assign mem_resp   = inj ? inj_d : mdl_d;

    stream_to_mem_mux #(
        .mem_req_t      (word_t),
        .mem_resp_t     (word_t),
        .NumPorts       (NP),
        .BufDepth       (1),
        .MaxOutstanding (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req_d),
        .req_valid_i      (req_v),
        .req_ready_o      (req_r),
        .resp_o           (resp_d),
        .resp_valid_o     (resp_v),
        .resp_ready_i     (resp_rdy),
        .mem_req_o        (mem_req),
        .mem_req_valid_o  (mem_req_v),
        .mem_req_ready_i  (mem_rdy),
        .mem_resp_i       (mem_resp),
        .mem_resp_valid_i (mem_resp_v),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endfunction

    typedef struct { int port; word_t data; } exp_t;
    typedef struct { int port; int unsigned c; } hs_t;
    typedef struct { int unsigned due; word_t data; } mem_ent_t;
    exp_t     sb[$];
    hs_t      hs_log[$];
    mem_ent_t mem_pipe[$];
    int unsigned lat = 1;

    // Memory: accepts on handshake, answers in order after lat cycles, never stalls responses.
    always @(negedge clk) begin
        if (mem_req_v && mem_rdy) mem_pipe.push_back('{cyc + lat, mem_req ^ 16'h5A5A});
    end

    always @(posedge clk) begin
        #1;
        mdl_v = 1'b0;
        if (mem_pipe.size() > 0 && mem_pipe[0].due <= cyc) begin
            mdl_v = 1'b1;
            mdl_d = mem_pipe[0].data;
            void'(mem_pipe.pop_front());
        end
    end

    always @(negedge clk) begin : monitor
        int g;
        int idx;
        if (rst_n) begin
            if (mem_req_v && mem_rdy) begin
                g = 0;
                for (int p = 0; p < int'(NP); p++) if (req_r[p]) g = p;
                check("ready_onehot", 32'($onehot(req_r)), 1);
                check("mem_req_payload", mem_req, req_d[g]);
                hs_log.push_back('{g, cyc});
            end
            for (int p = 0; p < int'(NP); p++) begin
                if (resp_v[p] && resp_rdy[p]) begin
                    idx = -1;
                    foreach (sb[i]) if (idx < 0 && sb[i].port == p) idx = i;
                    if (idx < 0) begin
                        checks++;
                        $display("FAIL unexpected_resp p%0d: got %0h, required no response", p, resp_d[p]);
                    end else begin
                        check($sformatf("resp_data_p%0d", p), resp_d[p], sb[idx].data);
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    task automatic issue(input int p, input word_t d);
        req_d[p] = d;
        req_v[p] = 1'b1;
        sb.push_back('{p, d ^ 16'h5A5A});
    endtask

    task automatic wait_hs(input int p);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = req_v[p] && req_r[p];
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            $display("FAIL hs_timeout p%0d: got no handshake, required one within 50 cycles", p);
        end
        req_v[p] = 1'b0;
    endtask

    task automatic send_seq(input int p, input word_t base, input int n);
        for (int k = 0; k < n; k++) begin
            issue(p, base + word_t'(k));
            wait_hs(p);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_v    = '0;
        req_d    = '0;
        resp_rdy = '1;
        mem_rdy  = 1'b0;

        // Reset state; request valid passes through to the memory side.
        idle(2);
        req_v = 3'b010;
        @(negedge clk);
        check("rst_mem_req_valid", mem_req_v, 1);
        check("rst_req_ready", req_r, 0);
        check("rst_resp_valid", resp_v, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        req_v   = '0;
        rst_n   = 1'b1;
        mem_rdy = 1'b1;

        // Two ports streaming, latency 1: strict alternation.
        hs_log.delete();
        fork
            send_seq(0, 16'h1000, 4);
            send_seq(1, 16'h2000, 4);
        join
        idle(6);
        check("p1_hs_count", hs_log.size(), 8);
        foreach (hs_log[i]) check($sformatf("p1_grant_%0d", i), hs_log[i].port, i % 2);

        // Port 0 response held: port 0 blocked, port 1 keeps going.
        resp_rdy[0] = 1'b0;
        issue(0, 16'h3000);
        wait_hs(0);
        issue(0, 16'h3001);
        fork
            send_seq(1, 16'h4000, 4);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("p2_port0_blocked", req_r[0], 0);
                    @(posedge clk);
                end
            end
        join
        resp_rdy[0] = 1'b1;
        @(negedge clk);
        check("p2_ready_returns", req_r[0], 1);
        @(posedge clk);
        #1;
        req_v[0] = 1'b0;
        idle(4);

        // Stalled memory: grant stays on port 1 although port 0 would win on rr.
        issue(1, 16'h5100);
        wait_hs(1);
        mem_rdy = 1'b0;
        issue(1, 16'h5000);
        @(posedge clk);
        #1;
        issue(0, 16'h6000);
        repeat (3) begin
            @(negedge clk);
            check("p3_payload_locked", mem_req, 16'h5000);
            check("p3_no_ready", req_r, 0);
            @(posedge clk);
            #1;
        end
        mem_rdy = 1'b1;
        @(negedge clk);
        check("p3_grant_port1", req_r, 3'b010);
        @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        wait_hs(0);
        idle(4);

        // Latency 4, two outstanding max: third issue waits for first response.
        lat = 4;
        hs_log.delete();
        issue(0, 16'h7000);
        issue(1, 16'h7100);
        issue(2, 16'h7200);
        fork
            wait_hs(0);
            wait_hs(1);
            wait_hs(2);
        join
        idle(8);
        check("p4_hs_count", hs_log.size(), 3);
        if (hs_log.size() == 3) begin
            check("p4_first_port", hs_log[0].port, 1);
            check("p4_third_port", hs_log[2].port, 0);
            check("p4_second_gap", hs_log[1].c - hs_log[0].c, 1);
            check("p4_third_gap", hs_log[2].c - hs_log[0].c, 4);
        end

        // Spurious memory response with nothing outstanding.
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        inj_d = 16'hBEEF;
        inj   = 1'b1;
        @(negedge clk);
        check("p5_drop_resp_valid", resp_v, 0);
        @(posedge clk);
        #1;
        inj = 1'b0;
        @(negedge clk);
        check("p5_drop_no_resp", resp_v, 0);
`ifdef STREAM_TO_MEM_MUX_ERR_EN
        check("p5_err", err, 1);
`else
        check("p5_err", err, 0);
`endif
        @(posedge clk);
        #1;

        // Reset with two requests in flight; rr would point at port 2 without reset.
        issue(0, 16'h8000);
        wait_hs(0);
        issue(1, 16'h8100);
        wait_hs(1);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("p6_rst_resp_valid", resp_v, 0);
        idle(2);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("p6_late_dropped", resp_v, 0);
            @(posedge clk);
            #1;
        end
        issue(2, 16'h9200);
        issue(0, 16'h9000);
        @(negedge clk);
        check("p6_first_grant_port0", req_r, 3'b001);
        @(posedge clk);
        #1;
        req_v[0] = 1'b0;
        wait_hs(2);
        idle(10);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/stream_to_mem_mux.md
STREAM_TO_MEM_MUX -- requirements
Module: stream_to_mem_mux

Interface
REQ-001 Parameter mem_req_t, logic: memory request payload type.
REQ-002 Parameter mem_resp_t, logic: memory response payload type.
REQ-003 Parameter NumPorts, 2: number of request/response stream ports; SHALL be >= 1.
REQ-004 Parameter BufDepth, 1: response buffer entries per port; SHALL be >= 1; memory latency SHALL be >= 1 cycle.
REQ-005 Parameter MaxOutstanding, NumPorts*BufDepth: total outstanding memory requests (ID FIFO depth); SHALL be >= 1.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_ni  in  1  reset; one clock, asynchronous, active-low.
REQ-008 req_i  in  NumPorts x mem_req_t  per-port request payload.
REQ-009 req_valid_i  in  NumPorts  per-port request valid.
REQ-010 req_ready_o  out  NumPorts  per-port request ready.
REQ-011 resp_o  out  NumPorts x mem_resp_t  per-port response payload.
REQ-012 resp_valid_o  out  NumPorts  per-port response valid.
REQ-013 resp_ready_i  in  NumPorts  per-port response ready.
REQ-014 mem_req_o  out  mem_req_t  memory request payload.
REQ-015 mem_req_valid_o  out  1  memory request valid.
REQ-016 mem_req_ready_i  in  1  memory request ready.
REQ-017 mem_resp_i  in  mem_resp_t  memory response payload, in request order.
REQ-018 mem_resp_valid_i  in  1  memory response valid, no back-pressure.
REQ-019 err_o  out  1  sticky protocol error flag.

Function
REQ-020 Port p SHALL be eligible iff req_valid_i[p], cnt[p] < BufDepth (or port p pops a response this cycle), and ID FIFO not full (or pops this cycle).
REQ-021 cnt[p] SHALL increment on port-p request handshake, decrement on port-p response handshake; both in one cycle leave it unchanged.
REQ-022 Arbitration SHALL be round-robin: grant the first eligible port at or after pointer rr, wrapping NumPorts-1 -> 0.
REQ-023 rr SHALL advance to (granted port + 1) mod NumPorts only on a memory handshake; otherwise unchanged.
REQ-024 If mem_req_valid_o=1 and mem_req_ready_i=0, grant SHALL lock to that port until handshake.
REQ-025 mem_req_o = req_i[grant], mem_req_valid_o = any eligible, req_ready_o[grant] = mem_req_ready_i, others 0; zero-cycle combinational path.
REQ-026 On each memory handshake, granted index SHALL be pushed into the ID FIFO (depth MaxOutstanding).
REQ-027 On mem_resp_valid_i, ID FIFO head SHALL be popped and mem_resp_i pushed into that port's fall-through FIFO (depth BufDepth); resp_valid_o same cycle if FIFO empty.
REQ-028 Simultaneous ID push and pop SHALL be legal in any state, including full and empty.
REQ-029 Responses on one port SHALL keep issue order; ports SHALL not block each other except via shared ID FIFO capacity.
REQ-030 Counter widths SHALL be $clog2(BufDepth+1) bits; no wrap in legal operation.
REQ-031 mem_resp_valid_i with ID FIFO empty SHALL drop the response (no port written).

Reset
REQ-032 Reset SHALL clear all cnt[p], rr to 0, ID and response FIFOs to empty, err_o to 0; resp_valid_o = 0, mem_req_valid_o follows req_valid_i.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding state immediately; late memory responses after reset follow REQ-031.

Configuration
REQ-034 Macro STREAM_TO_MEM_MUX_ERR_EN defined: err_o SHALL set one cycle after a dropped response (REQ-031) or a response to a full port FIFO, holding until reset.
REQ-035 Macro undefined: err_o SHALL tie to 0 with no error logic; data behaviour unchanged.

Verification
REQ-036 NumPorts=2, BufDepth=1, both valid, memory ready, latency 1 -> grants 0,1,0,1; each port gets its own data.
REQ-037 Port 0 holds resp_ready_i=0 after one request -> req_ready_o[0]=0 while port 1 keeps issuing; ready returns the cycle resp_ready_i[0]=1.
REQ-038 mem_req_ready_i=0 for 3 cycles with port 1 granted, port 0 valid -> mem_req_o stays port 1 payload, grant unchanged until handshake.
REQ-039 MaxOutstanding=2, latency 4, 3 ports valid -> at most 2 outstanding; third issue waits for first response.
REQ-040 ERR_EN defined, mem_resp_valid_i pulse after reset with nothing outstanding -> err_o=1 next cycle, no resp_valid_o; undefined -> err_o=0.
REQ-041 Reset asserted with 2 outstanding -> all resp_valid_o=0, rr=0, first post-reset request granted from port 0.
